// File: rtl/udp_payload_pingpong.sv
// Ping-pong payload store for mk_to_udp_sender: packs a 32-bit word stream into two
// 2048-word banks, seals a bank on fill or flush, and hands sealed banks to the sender.
module udp_payload_pingpong #(
  parameter int FRAME_WORDS = 256,
  parameter int TX_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        flush,
  input  logic [10:0] mem_adr_rd,
  output logic [31:0] mem_data,
  output logic [15:0] mem_length,
  output logic [31:0] crc_data,
  output logic        tx_en,
  input  logic        END_TX,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic [1:0]  dbg_state,
  output logic        dbg_wr_bank
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_END = 2'd2,
    RELEASE  = 2'd3
  } rd_state_t;

  localparam logic [10:0] FRAME_LAST = 11'(FRAME_WORDS);
  localparam logic [15:0] TIMEOUT_M1 = (TX_TIMEOUT == 0) ? 16'd0 : 16'(TX_TIMEOUT - 1);

  logic [31:0] bank0 [0:2047];
  logic [31:0] bank1 [0:2047];

  logic        wr_bank;
  logic        rd_bank;
  logic [10:0] wr_ptr;
  logic [31:0] wr_sum;
  logic [1:0]  full;
  logic [15:0] len_d [0:1];
  logic [31:0] sum_d [0:1];
  rd_state_t   state;
  logic [15:0] wait_cnt;

  logic        wr_fire;
  logic [10:0] ptr_next;
  logic [10:0] wr_addr;
  logic [31:0] half_sum;
  logic [31:0] sum_next;
  logic        seal;
  logic        release_now;
  logic        other_free;

  // Handshake: a word is accepted when din_valid and din_ready are both high at the
  // clock edge; din_valid while din_ready is low drops the word (no backpressure stall).
  always_comb begin
    wr_fire     = din_valid & din_ready;
    wr_addr     = wr_ptr + 11'd1;
    ptr_next    = wr_fire ? wr_addr : wr_ptr;
    half_sum    = 32'(din[31:16]) + 32'(din[15:0]);
    sum_next    = wr_fire ? (wr_sum + half_sum) : wr_sum;
    seal        = din_ready & ((ptr_next == FRAME_LAST) | (flush & (ptr_next != 11'd0)));
    release_now = (state == RELEASE);
    // The bank being released this cycle counts as free for the toggle decision.
    other_free  = ~full[~wr_bank] | (release_now & (rd_bank == ~wr_bank));
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank) bank1[wr_addr] <= din;
      else         bank0[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data <= 32'd0;
    end else if (mem_adr_rd == 11'd0) begin
      mem_data <= 32'd0;
    end else begin
      mem_data <= rd_bank ? bank1[mem_adr_rd] : bank0[mem_adr_rd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_ptr    <= 11'd0;
      wr_sum    <= 32'd0;
      full      <= 2'b00;
      len_d[0]  <= 16'd0;
      len_d[1]  <= 16'd0;
      sum_d[0]  <= 32'd0;
      sum_d[1]  <= 32'd0;
      din_ready <= 1'b1;
      overflow  <= 1'b0;
      drop_cnt  <= 16'd0;
    end else begin
      if (din_valid & ~din_ready) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end

      if (release_now) full[rd_bank] <= 1'b0;

      if (seal) begin
        full[wr_bank]  <= 1'b1;
        len_d[wr_bank] <= 16'({ptr_next, 2'b00});
        sum_d[wr_bank] <= sum_next;
        wr_ptr         <= 11'd0;
        wr_sum         <= 32'd0;
        if (other_free) wr_bank   <= ~wr_bank;
        else            din_ready <= 1'b0;
      end else begin
        wr_ptr <= ptr_next;
        wr_sum <= sum_next;
        // Blocked writer resumes in the bank that was just freed.
        if (release_now & ~din_ready) begin
          din_ready <= 1'b1;
          wr_bank   <= rd_bank;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_bank  <= 1'b0;
      tx_en    <= 1'b0;
      wait_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state <= START;
            tx_en <= 1'b1;
          end
        end
        START: begin
          tx_en    <= 1'b0;
          state    <= WAIT_END;
          wait_cnt <= 16'd1;
        end
        WAIT_END: begin
          // wait_cnt holds the number of cycles elapsed since the tx_en cycle.
          wait_cnt <= wait_cnt + 16'd1;
          if (END_TX) begin
            state <= RELEASE;
          end else if ((TX_TIMEOUT != 0) && (wait_cnt >= TIMEOUT_M1)) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          rd_bank <= ~rd_bank;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

  assign mem_length  = len_d[rd_bank];
  assign crc_data    = sum_d[rd_bank];
  assign dbg_state   = state;
  assign dbg_wr_bank = wr_bank;

endmodule

// File: tb/tb_udp_payload_pingpong.sv
// Directed bench for udp_payload_pingpong: expected frame descriptors go into a queue
// at stimulus time; a monitor pops and compares them on every tx_en pulse.
`timescale 1ns/1ps
module tb_udp_payload_pingpong;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = 32'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        flush = 1'b0;
  logic [10:0] mem_adr_rd = 11'd0;
  logic [31:0] mem_data;
  logic [15:0] mem_length;
  logic [31:0] crc_data;
  logic        tx_en;
  logic        end_tx = 1'b0;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;
  logic        dbg_wr_bank;

  int checks = 0;
  int failures = 0;
  int tx_seen = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;

  udp_payload_pingpong #(.FRAME_WORDS(4), .TX_TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .flush(flush), .mem_adr_rd(mem_adr_rd), .mem_data(mem_data), .mem_length(mem_length),
    .crc_data(crc_data), .tx_en(tx_en), .END_TX(end_tx), .overflow(overflow),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state), .dbg_wr_bank(dbg_wr_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
    end
  endtask

  // Monitor: every tx_en must match the oldest expected descriptor.
  always @(negedge clk) begin
    if (rst_n && tx_en) begin
      tx_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx_en actual=1 required=0 (len=0x%0h crc=0x%0h)", mem_length, crc_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_length", 32'(mem_length), 32'(mon_e[47:32]));
        check("crc_data", crc_data, mon_e[31:0]);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic f, input logic e);
    @(negedge clk);
    din_valid = v;
    din = d;
    flush = f;
    end_tx = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_tx(input string name, input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      if (tx_en) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL %s tx_en_wait actual=none required=pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic read_check(input logic [10:0] a, input logic [31:0] want, input string name);
    @(negedge clk);
    mem_adr_rd = a;
    din_valid = 1'b0;
    flush = 1'b0;
    end_tx = 1'b0;
    @(negedge clk);
    check(name, mem_data, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_rel;
    logic [1:0] st20;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_mem_length", 32'(mem_length), 32'd0);
    check("rst_crc_data", crc_data, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: full frame, readback
    exp_q.push_back({16'd16, 32'h24});
    drive(1'b1, 32'h00010002, 1'b0, 1'b0);
    drive(1'b1, 32'h00030004, 1'b0, 1'b0);
    drive(1'b1, 32'h00050006, 1'b0, 1'b0);
    drive(1'b1, 32'h00070008, 1'b0, 1'b0);
    wait_tx("t1", 10, n);
    check("t1_tx_latency", 32'(n), 32'd2);
    read_check(11'd1, 32'h00010002, "t1_rd_a1");
    read_check(11'd2, 32'h00030004, "t1_rd_a2");
    read_check(11'd3, 32'h00050006, "t1_rd_a3");
    read_check(11'd4, 32'h00070008, "t1_rd_a4");
    read_check(11'd0, 32'h0, "t1_rd_a0");
    check("t1_wait_state", 32'(dbg_state), 32'd2);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t1_release_state", 32'(dbg_state), 32'd3);
    idle(2);

    // 2: empty flush ignored, then flush with third word
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    idle(3);
    check("t2_empty_flush_bank", 32'(dbg_wr_bank), 32'd1);
    exp_q.push_back({16'd12, 32'h150});
    drive(1'b1, 32'h00100020, 1'b0, 1'b0);
    drive(1'b1, 32'h00300040, 1'b0, 1'b0);
    drive(1'b1, 32'h00500060, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t2_wr_bank_toggle", 32'(dbg_wr_bank), 32'd0);
    wait_tx("t2", 10, n);
    check("t2_tx_latency", 32'(n), 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    idle(3);

    // 3: both banks full, drops, release reopens, spacing of next tx_en
    exp_q.push_back({16'd16, 32'h8});
    exp_q.push_back({16'd16, 32'h40000});
    repeat (4) drive(1'b1, 32'h00010001, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 32'hFFFF0001, 1'b0, 1'b0);
    repeat (5) drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t3_din_ready_blocked", 32'(din_ready), 32'd0);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd5);
    check("t3_overflow", 32'(overflow), 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t3_release_state", 32'(dbg_state), 32'd3);
    check("t3_still_blocked", 32'(din_ready), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t3_din_ready_reopen", 32'(din_ready), 32'd1);
    check("t3_reopen_bank", 32'(dbg_wr_bank), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t3_tx_spacing", 32'(tx_en), 32'd1);

    // 5a: seal bank0 in the same cycle as END_TX for bank1
    exp_q.push_back({16'd16, 32'h14});
    drive(1'b1, 32'h00020003, 1'b0, 1'b0);
    drive(1'b1, 32'h00020003, 1'b0, 1'b0);
    drive(1'b1, 32'h00020003, 1'b0, 1'b0);
    drive(1'b1, 32'h00020003, 1'b0, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t5a_blocked", 32'(din_ready), 32'd0);
    check("t5a_release_state", 32'(dbg_state), 32'd3);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t5a_reopen", 32'(din_ready), 32'd1);
    check("t5a_wr_bank", 32'(dbg_wr_bank), 32'd1);
    wait_tx("t5a", 10, n);
    check("t5a_tx_latency", 32'(n), 32'd1);

    // 5b: seal bank1 in the RELEASE cycle of bank0
    exp_q.push_back({16'd16, 32'h7F8});
    drive(1'b1, 32'h00FF00FF, 1'b0, 1'b0);
    drive(1'b1, 32'h00FF00FF, 1'b0, 1'b0);
    drive(1'b1, 32'h00FF00FF, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 32'h00FF00FF, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    check("t5b_din_ready", 32'(din_ready), 32'd1);
    check("t5b_wr_bank", 32'(dbg_wr_bank), 32'd0);
    wait_tx("t5b", 10, n);
    check("t5b_tx_latency", 32'(n), 32'd1);

    // 4: no END_TX, timeout releases after 20 cycles, pending frame follows
    exp_q.push_back({16'd16, 32'h4});
    n_rel = 0;
    st20 = 2'd0;
    for (int i = 1; i <= 40; i++) begin
      drive((i <= 4) ? 1'b1 : 1'b0, 32'h00000001, 1'b0, 1'b0);
      if (i == 20) st20 = dbg_state;
      if (tx_en) begin
        n_rel = i;
        break;
      end
    end
    check("t4_release_at_20", 32'(st20), 32'd3);
    check("t4_next_tx_cycle", 32'(n_rel), 32'd22);

    // 6: asynchronous reset during WAIT_END
    idle(3);
    check("t6_wait_state", 32'(dbg_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tx_en", 32'(tx_en), 32'd0);
    check("t6_din_ready", 32'(din_ready), 32'd1);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t6_mem_length", 32'(mem_length), 32'd0);
    check("t6_crc_data", crc_data, 32'd0);
    check("t6_state", 32'(dbg_state), 32'd0);
    check("t6_mem_data", mem_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("t6_tx_total", 32'(tx_seen), 32'd7);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
